clk_trig_encoder: RTL and testbench

CLK_TRIG_ENCODER -- requirements
Module: clk_trig_encoder

---
 rtl/clk_trig_pkg.sv | 35 +++
 rtl/clk_trig_encoder_if.sv | 27 ++
 rtl/clk_trig_encoder_sync.sv | 30 +++
 rtl/clk_trig_encoder.sv | 146 ++++++++++++++
 tb/tb_clk_trig_encoder.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/clk_trig_pkg.sv
// clk_trig_pkg -- shared definitions for the clock/trigger encoder.
//   MODE_DUTY / MODE_MISS : encoding selected by the mode input
//   ptype_e               : kind of output period being generated (IDLE/TRIG)
//   clog2()               : phase counter width for a given DIV
//   clk_pattern()         : encoded clock level for a phase within a period
package clk_trig_pkg;

  localparam logic MODE_DUTY = 1'b0;  // 75% idle / 25% trigger high time
  localparam logic MODE_MISS = 1'b1;  // 50% idle / trigger period held low

  typedef enum logic {
    IDLE = 1'b0,
    TRIG = 1'b1
  } ptype_e;

  function automatic int clog2(input int unsigned v);
    int r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  // Rising edges only ever fall on a single phase per period and the level
  // is 0 at phase 0, so a registered copy of this is glitch/runt free.
  function automatic logic clk_pattern(input int unsigned ph, input ptype_e pt,
                                       input logic md, input int unsigned div);
    logic hi;
    if (md == MODE_DUTY)
      hi = (pt == TRIG) ? (ph >= (3 * div) / 4) : (ph >= div / 4);
    else
      hi = (pt == TRIG) ? 1'b0 : (ph >= div / 2);
    return hi;
  endfunction

endpackage

// File: rtl/clk_trig_encoder_if.sv
// clk_trig_encoder_if -- control/status bundle of the clock/trigger encoder.
//   master : drives trigger, mode, ch_en, holdoff, clr; observes outputs
//   slave  : the encoder side (clk_out, trig_s, trig_lost, trig_count out)
interface clk_trig_encoder_if #(
  parameter int N_CH  = 4,
  parameter int W_CNT = 16
);
  logic             trigger;     // async trigger request, rising edge = event
  logic             mode;        // 0 duty-cycle, 1 missing-clock
  logic [N_CH-1:0]  ch_en;       // per-channel output enable
  logic [7:0]       holdoff;     // forced idle periods after a trigger period
  logic             clr;         // synchronous clear of the statistics
  logic [N_CH-1:0]  clk_out;     // encoded clocks
  logic             trig_s;      // high during trigger periods
  logic             trig_lost;   // sticky: an event was discarded
  logic [W_CNT-1:0] trig_count;  // trigger periods encoded (wrapping)

  modport master (
    output trigger, mode, ch_en, holdoff, clr,
    input  clk_out, trig_s, trig_lost, trig_count
  );

  modport slave (
    input  trigger, mode, ch_en, holdoff, clr,
    output clk_out, trig_s, trig_lost, trig_count
  );
endinterface

// File: rtl/clk_trig_encoder_sync.sv
// trig_edge_sync -- brings the asynchronous trigger into the clk_i domain
// and turns its rising edge into a one-cycle pulse.
//   clk_i   : sampling clock
//   rst_ni  : async active-low reset
//   trig_i  : asynchronous trigger level
//   pulse_o : one cycle wide; acted on at the 3rd clk_i edge after trig_i rises
module trig_edge_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic trig_i,
  output logic pulse_o
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= trig_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign pulse_o = sync_q & ~prev_q;

endmodule

// File: rtl/clk_trig_encoder.sv
// clk_trig_encoder -- encodes trigger events into N_CH copies of a divided
// clock. Each output period (DIV fastclk cycles) is either an idle period or
// a trigger period; the two are told apart by duty cycle (mode 0) or by a
// missing high pulse (mode 1).
//   fastclk : sole clock
//   reset   : async active-low reset
//   bus     : clk_trig_encoder_if.slave (trigger/mode/ch_en/holdoff/clr in,
//             clk_out/trig_s/trig_lost/trig_count out)
// Build option: CLK_TRIG_ENCODER_COUNT_EN enables trig_count/trig_lost;
// without it both are tied to 0 and clr is ignored.
module clk_trig_encoder
  import clk_trig_pkg::*;
#(
  parameter int DIV   = 4,
  parameter int N_CH  = 4,
  parameter int W_CNT = 16
) (
  input  logic              fastclk,
  input  logic              reset,
  clk_trig_encoder_if.slave bus
);

  localparam int PW = clog2(DIV);

  logic [PW-1:0]   phase_q, phase_d;
  logic            boundary;
  logic            pulse;
  logic            pending_q, pending_d;
  logic [7:0]      hold_q, hold_d;
  logic            start_trig;
  ptype_e          ptype_q, ptype_d;
  logic            mode_q, mode_d;
  logic [N_CH-1:0] chen_q, chen_d;
  logic [N_CH-1:0] clk_out_q, clk_out_d;
  logic            pat;

  trig_edge_sync u_sync (
    .clk_i  (fastclk),
    .rst_ni (reset),
    .trig_i (bus.trigger),
    .pulse_o(pulse)
  );

  // ---------------------------------------------------------------- phase
  assign boundary = (phase_q == PW'(DIV - 1));
  assign phase_d  = boundary ? '0 : phase_q + PW'(1);

  // ------------------------------------------------- pending / holdoff
  // A pulse arriving on the boundary itself is eligible for that boundary.
  assign start_trig = boundary & (pending_q | pulse) & (hold_q == 8'd0);

  always_comb begin
    pending_d = pending_q | pulse;
    hold_d    = hold_q;
    if (start_trig) begin
      // If a stored event was consumed, a same-cycle pulse becomes the new
      // pending one; if the pulse itself was consumed nothing is left.
      pending_d = pending_q & pulse;
      hold_d    = bus.holdoff;
    end else if (boundary && hold_q != 8'd0) begin
      hold_d    = hold_q - 8'd1;
    end
  end

  // Mode and enables are only sampled at a boundary so a period is always
  // generated with one consistent configuration.
  assign mode_d = boundary ? bus.mode  : mode_q;
  assign chen_d = boundary ? bus.ch_en : chen_q;

  always_ff @(posedge fastclk or negedge reset) begin
    if (!reset) begin
      phase_q   <= '0;
      pending_q <= 1'b0;
      hold_q    <= 8'd0;
      mode_q    <= MODE_DUTY;
      chen_q    <= '0;
    end else begin
      phase_q   <= phase_d;
      pending_q <= pending_d;
      hold_q    <= hold_d;
      mode_q    <= mode_d;
      chen_q    <= chen_d;
    end
  end

  // ------------------------------------------------- period type FSM
  always_ff @(posedge fastclk or negedge reset) begin
    if (!reset) ptype_q <= IDLE;
    else        ptype_q <= ptype_d;
  end

  always_comb begin
    ptype_d = ptype_q;
    if (boundary) ptype_d = start_trig ? TRIG : IDLE;
  end

  // Outputs are computed from the state being entered so clk_out moves on
  // the same edge as the phase counter.
  always_comb begin
    pat = clk_pattern(32'(phase_d), ptype_d, mode_d, DIV);
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign clk_out_d[g] = chen_d[g] & pat;
  end

  always_ff @(posedge fastclk or negedge reset) begin
    if (!reset) clk_out_q <= '0;
    else        clk_out_q <= clk_out_d;
  end

  assign bus.clk_out = clk_out_q;
  assign bus.trig_s  = (ptype_q == TRIG);

  // ------------------------------------------------- statistics
`ifdef CLK_TRIG_ENCODER_COUNT_EN
  logic [W_CNT-1:0] cnt_q;
  logic             lost_q;
  logic             lost_ev;

  // Second event while one is still waiting and not taken this cycle.
  assign lost_ev = pulse & pending_q & ~start_trig;

  always_ff @(posedge fastclk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      lost_q <= 1'b0;
    end else if (bus.clr) begin
      cnt_q  <= '0;
      lost_q <= 1'b0;
    end else begin
      if (start_trig) cnt_q  <= cnt_q + W_CNT'(1);
      if (lost_ev)    lost_q <= 1'b1;
    end
  end

  assign bus.trig_count = cnt_q;
  assign bus.trig_lost  = lost_q;
`else
  logic unused_clr;
  assign unused_clr     = bus.clr;
  assign bus.trig_count = '0;
  assign bus.trig_lost  = 1'b0;
`endif

endmodule

// File: tb/tb_clk_trig_encoder.sv
module tb_clk_trig_encoder;
  localparam int DIV   = 8;
  localparam int N_CH  = 4;
  localparam int W_CNT = 16;
`ifdef CLK_TRIG_ENCODER_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  clk_trig_encoder_if #(.N_CH(N_CH), .W_CNT(W_CNT)) bus ();

  clk_trig_encoder #(.DIV(DIV), .N_CH(N_CH), .W_CNT(W_CNT)) dut (
    .fastclk(clk),
    .reset  (rst_n),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model (edge-count based) ----------------
  bit   hist[$];        // trigger level seen at each edge since reset
  int   c;              // edges since reset release
  bit   m_pend, m_trig, m_mode, m_lost;
  bit   [3:0] m_chen;
  int   m_hold, m_cnt;

  task automatic m_reset();
    hist.delete();
    c = 0; m_pend = 0; m_trig = 0; m_mode = 0; m_lost = 0;
    m_chen = 4'h0; m_hold = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    int n;
    bit pulse, start, lost_ev;
    hist.push_back(bus.trigger);
    n = hist.size() - 1;
    // event is recognised 3 edges after the first edge that sees the rise
    pulse   = (n >= 2 && hist[n-2]) && (n < 3 || !hist[n-3]);
    lost_ev = 0;
    start   = 0;
    if (((c + 1) % DIV) == 0) begin
      start = (m_pend || pulse) && (m_hold == 0);
      if (start) begin
        m_pend = m_pend ? pulse : 1'b0;
        m_hold = int'(bus.holdoff);
      end else begin
        if (pulse && m_pend) lost_ev = 1;
        m_pend = m_pend || pulse;
        if (m_hold > 0) m_hold = m_hold - 1;
      end
      m_trig = start;
      m_mode = bus.mode;
      m_chen = bus.ch_en;
    end else begin
      if (pulse && m_pend) lost_ev = 1;
      m_pend = m_pend || pulse;
    end
    if (bus.clr) begin
      m_cnt = 0; m_lost = 0;
    end else begin
      if (start) m_cnt = (m_cnt + 1) % 65536;
      if (lost_ev) m_lost = 1;
    end
    c++;
  endtask

  function automatic logic [3:0] exp_clk();
    int p;
    bit hi;
    logic [3:0] r;
    p = c % DIV;
    if (m_trig) hi = m_mode ? 1'b0 : (4 * p >= 3 * DIV);
    else        hi = m_mode ? (2 * p >= DIV) : (4 * p >= DIV);
    for (int i = 0; i < N_CH; i++) r[i] = m_chen[i] & hi;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
      $error("check %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("clk_out",    32'(bus.clk_out),    32'(exp_clk()));
    chk("trig_s",     32'(bus.trig_s),     32'(m_trig));
    chk("trig_count", 32'(bus.trig_count), CNT_ON ? 32'(m_cnt)  : 32'd0);
    chk("trig_lost",  32'(bus.trig_lost),  CNT_ON ? 32'(m_lost) : 32'd0);
  endtask

  // advance until the model is at the given phase (bounded)
  task automatic align(input int ph);
    int k;
    k = 0;
    while ((c % DIV) != ph && k < 2 * DIV) begin
      tick();
      k++;
    end
    chk("align", 32'(c % DIV), 32'(ph));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_clk"},  32'(bus.clk_out),    32'd0);
    chk({tag, "_ts"},   32'(bus.trig_s),     32'd0);
    chk({tag, "_cnt"},  32'(bus.trig_count), 32'd0);
    chk({tag, "_lost"}, 32'(bus.trig_lost),  32'd0);
  endtask

  int hi_sum, k;

  initial begin
    rst_n = 1'b1;
    bus.trigger = 0; bus.mode = 0; bus.ch_en = 4'hF; bus.holdoff = 8'd0; bus.clr = 0;
    m_reset();
    #3 rst_n = 1'b0;
    #1 chk_reset_outputs("rst0");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    m_reset();

    // mode 0 idle: 6 of 8 phases high
    repeat (2 * DIV) tick();
    align(0);
    hi_sum = int'(bus.clk_out[0]);
    repeat (DIV - 1) begin tick(); hi_sum += int'(bus.clk_out[0]); end
    chk("idle_duty_hi", 32'(hi_sum), 32'd6);

    // mode 0 single trigger: one period with 2 high phases
    bus.trigger = 1; tick(); tick(); bus.trigger = 0;
    k = 0;
    while (!bus.trig_s && k < 3 * DIV) begin tick(); k++; end
    chk("trig_seen", 32'(bus.trig_s), 32'd1);
    hi_sum = int'(bus.clk_out[0]);
    repeat (DIV - 1) begin tick(); hi_sum += int'(bus.clk_out[0]); end
    chk("trig_duty_hi", 32'(hi_sum), 32'd2);
    tick();
    chk("trig_s_drop", 32'(bus.trig_s), 32'd0);
    chk("cnt_one", 32'(bus.trig_count), CNT_ON ? 32'd1 : 32'd0);
    repeat (DIV) tick();

    // mode 1, holdoff 2, second trigger during holdoff
    bus.mode = 1; bus.holdoff = 8'd2;
    repeat (DIV) tick();
    bus.trigger = 1; tick(); tick(); bus.trigger = 0;
    k = 0;
    while (!bus.trig_s && k < 3 * DIV) begin tick(); k++; end
    chk("miss_seen", 32'(bus.trig_s), 32'd1);
    hi_sum = int'(bus.clk_out[0]);
    for (int i = 1; i < DIV; i++) begin
      if (i == 2) bus.trigger = 1;
      if (i == 4) bus.trigger = 0;
      tick();
      hi_sum += int'(bus.clk_out[0]);
    end
    chk("miss_all_low", 32'(hi_sum), 32'd0);
    k = 0;
    do begin tick(); k++; end while (!bus.trig_s && k < 5 * DIV);
    chk("holdoff_gap", 32'(k), 32'(2 * DIV + 1));
    repeat (2 * DIV) tick();

    // two edges inside one period -> one trigger period and a lost flag
    bus.mode = 0; bus.holdoff = 8'd0;
    repeat (2 * DIV) tick();
    align(0);
    bus.trigger = 1; tick(); bus.trigger = 0; tick();
    bus.trigger = 1; tick(); bus.trigger = 0;
    repeat (3 * DIV) tick();
    chk("lost_set", 32'(bus.trig_lost), CNT_ON ? 32'd1 : 32'd0);
    bus.clr = 1; tick(); bus.clr = 0;
    chk("clr_cnt",  32'(bus.trig_count), 32'd0);
    chk("clr_lost", 32'(bus.trig_lost),  32'd0);
    repeat (DIV) tick();

    // ch_en change mid-period only takes effect at the next boundary
    align(3);
    bus.ch_en = 4'h5;
    tick();
    chk("chen_hold", 32'(bus.clk_out), 32'hF);
    align(3);
    chk("chen_new", 32'(bus.clk_out), 32'h5);
    bus.ch_en = 4'hF;

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0)  bus.trigger = ~bus.trigger;
      if ($urandom_range(0, 39) == 0) bus.mode = $urandom_range(0, 1);
      if ($urandom_range(0, 19) == 0) bus.ch_en = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) bus.holdoff = 8'($urandom_range(0, 3));
      bus.clr = ($urandom_range(0, 59) == 0);
      tick();
    end
    bus.clr = 0; bus.trigger = 0; bus.mode = 0; bus.ch_en = 4'hF; bus.holdoff = 8'd0;
    repeat (2 * DIV) tick();

    // reset mid-period with a trigger pending: outputs drop at once
    align(2);
    bus.trigger = 1; tick(); tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("rst_mid");
    bus.trigger = 0;
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    repeat (3 * DIV) tick();
    chk("no_stale_trig", 32'(bus.trig_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
